instruction_fetch_unit: RTL

Sequential front end of the CoreTech processor. It owns the program counter, fetches 32-bit instruction words from instruction memory over a request/valid handshake, and holds each word in an instruction register. It presents the opcode and operand fields to the control logic unit and consumes that unit's `Jump` and `Halt` decisions to compute the next PC or stop the core.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/program_counter.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-unit types, instruction field positions and opcodes
// Contents: state_e (fetch FSM states), instruction field bit positions,
// OP_JMP / OP_HALT opcode values shared with the control unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 24;
  localparam int RD_MSB  = 23;
  localparam int RD_LSB  = 20;
  localparam int RS_MSB  = 19;
  localparam int RS_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [7:0] OP_JMP  = 8'h05;
  localparam logic [7:0] OP_HALT = 8'hFF;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with load, increment and hold
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pc -> 0)
//   load_en   : load load_val (has priority over inc_en)
//   load_val  : jump target
//   inc_en    : pc <= pc + 1, wrapping modulo 2^PC_W
//   pc        : current program counter
module program_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch/execute sequencer owning PC and instruction register
// Optional feature macro: FETCH_ICOUNT_EN (adds 32-bit executed-instruction counter port icount).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   imem_req/imem_addr            : fetch request and address (address = pc)
//   imem_valid/imem_rdata         : fetch response, accepted only while requesting in S_FETCH
//   opcode/rd/rs/imm              : registered instruction fields
//   exec_valid                    : high for the single execute cycle
//   jump/halt                     : control-unit decisions, sampled in the execute cycle
//   pc, halted                    : program counter, core-stopped flag
//   icount (FETCH_ICOUNT_EN only) : executed-instruction count
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [7:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [15:0]        imm,
  output logic               exec_valid,
  input  logic               jump,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic               halted
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [31:0]        icount
`endif
);

  state_e             state_q;
  state_e             state_d;
  logic               req_q;
  logic               req_d;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_d;
  logic               pc_load;
  logic               pc_inc;
  logic               fetch_done;

  // req_q is registered so the request stays low in the first cycle after
  // reset; a response is only taken while the request is actually up.
  assign fetch_done = (state_q == S_FETCH) && req_q && imem_valid;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_done) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // halt outranks jump: pc is left pointing at the halt instruction
        if (halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          if (jump) begin
            pc_load = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      req_q   <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ir_q    <= ir_d;
    end
  end

  // Jump target is the low PC_W bits of imm (PC_W must not exceed 16).
  program_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load_en  (pc_load),
    .load_val (imm[PC_W-1:0]),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  assign imem_req   = req_q;
  assign imem_addr  = pc;
  assign opcode     = ir_q[OP_MSB:OP_LSB];
  assign rd         = ir_q[RD_MSB:RD_LSB];
  assign rs         = ir_q[RS_MSB:RS_LSB];
  assign imm        = ir_q[IMM_MSB:IMM_LSB];
  assign exec_valid = (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);

`ifdef FETCH_ICOUNT_EN
  logic [31:0] icount_q;
  logic [31:0] icount_d;

  // Counting only in S_EXEC freezes the count once halted.
  always_comb begin
    icount_d = icount_q;
    if (state_q == S_EXEC) begin
      icount_d = icount_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount_q <= '0;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign icount = icount_q;
`endif

endmodule
